// File: rtl/tcdm_bank_responder.sv
// TCDM bank endpoint: turns flattened TCDM requests into single-port SRAM accesses.
// It returns one response per grant, AccessLatency cycles after that grant.
// After reset it can optionally zero-fill the whole bank before it grants anything.
module tcdm_bank_responder #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrMemWidth  = 4,
    parameter int unsigned NumBanks      = 4,
    parameter int unsigned AccessLatency = 1,
    parameter int unsigned InitEnable    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic                    req_write_i,
    input  logic [DataWidth-1:0]    req_data_i,
    input  logic [DataWidth/8-1:0]  req_strb_i,
    output logic                    rsp_valid_o,
    output logic [DataWidth-1:0]    rsp_data_o,
    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [AddrMemWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]    sram_wdata_o,
    output logic [DataWidth/8-1:0]  sram_be_o,
    input  logic [DataWidth-1:0]    sram_rdata_i,
    output logic                    init_done_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    // Drop the byte-in-word bits and the bank-select bits of the interleaved address.
    localparam int unsigned AddrLsb   = $clog2(StrbWidth) + $clog2(NumBanks);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    localparam state_e ResetState = (InitEnable != 0) ? StInit : StReady;

    state_e                   state_q;
    logic [AddrMemWidth-1:0]  init_cnt_q;
    logic [AccessLatency-1:0] pipe_valid_q;
    logic [AccessLatency-1:0] pipe_read_q;

    logic in_init;
    logic in_ready;
    logic grant;
    logic rsp_read;

    // Outputs are held low while reset is asserted, so both state decodes are qualified with it.
    assign in_init  = rst_ni && (state_q == StInit);
    assign in_ready = rst_ni && (state_q == StReady);
    assign grant    = in_ready && req_valid_i;

    assign req_ready_o = in_ready;
    assign init_done_o = in_ready;

    // Init sweep: write every word once, then hand the bank over to requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ResetState;
            init_cnt_q <= '0;
        end else if (state_q == StInit) begin
            init_cnt_q <= init_cnt_q + AddrMemWidth'(1);
            if (&init_cnt_q) begin
                state_q <= StReady;
            end
        end
    end

    // SRAM port: the init sweep owns the macro during INIT, and requests pass straight through afterwards.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (in_init) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = init_cnt_q;
            sram_be_o    = '1;
        end else if (in_ready) begin
            sram_req_o   = req_valid_i;
            sram_we_o    = req_write_i;
            sram_addr_o  = req_addr_i[AddrLsb +: AddrMemWidth];
            sram_wdata_o = req_data_i;
            sram_be_o    = req_strb_i;
        end
    end

    // Response tracker: one {valid, is_read} slot per cycle of access latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            pipe_read_q  <= '0;
        end else begin
            pipe_valid_q[0] <= grant;
            pipe_read_q[0]  <= grant && !req_write_i;
            for (int unsigned i = 1; i < AccessLatency; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_read_q[i]  <= pipe_read_q[i-1];
            end
        end
    end

    assign rsp_valid_o = pipe_valid_q[AccessLatency-1];
    assign rsp_read    = pipe_valid_q[AccessLatency-1] && pipe_read_q[AccessLatency-1];

    if (AccessLatency == 1) begin : gen_rdata_direct
        // Read data arrives in the response cycle itself, so it passes through untouched.
        assign rsp_data_o = rsp_read ? sram_rdata_i : '0;
    end else begin : gen_rdata_pipe
        logic [DataWidth-1:0] data_q [AccessLatency-1];

        // Capture read data one cycle after the grant, then age it until the response is due.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < AccessLatency - 1; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                data_q[0] <= pipe_read_q[0] ? sram_rdata_i : '0;
                for (int unsigned i = 1; i < AccessLatency - 1; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign rsp_data_o = rsp_read ? data_q[AccessLatency-2] : '0;
    end

    // Only a slice of the byte address selects the word.
    logic unused_addr;
    assign unused_addr = ^req_addr_i;

endmodule
